seq_byte_compare_ctrl: RTL and testbench

//  Sequencer that compares two NBYTES-wide operands using a single shared 8-bit

---
 rtl/seq_byte_compare_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seq_byte_compare_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_byte_compare_ctrl.sv
// Byte-serial magnitude comparator sequencer.
// Compares two NBYTES-wide operands one byte per clock, MSB byte first, through
// a single 8-bit cascadable compare stage. It stops early once a byte differs.
// It also owns the eq/gt cascade state, the byte index and the start/done handshake.
module seq_byte_compare_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_md,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic                  eq_out,
    output logic                  gt_out,
    output logic                  lt_out
);

    localparam int              IDXW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [IDXW-1:0]       r_idx;
    logic                  r_eq;
    logic                  r_gt;
    logic [8*NBYTES-1:0]   r_a;
    logic [8*NBYTES-1:0]   r_b;
    logic                  r_signed;
    logic                  r_eq_out;
    logic                  r_gt_out;
    logic                  r_lt_out;

    logic [7:0]            w_a_bytes [NBYTES];
    logic [7:0]            w_b_bytes [NBYTES];
    logic [7:0]            w_a_byte;
    logic [7:0]            w_b_byte;
    logic                  w_flip;
    logic [7:0]            w_a_stage;
    logic [7:0]            w_b_stage;
    logic                  w_stage_eq;
    logic                  w_stage_gt;

    // Split the latched operands into byte lanes so the index can pick one.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lanes
            assign w_a_bytes[gi] = r_a[8*gi +: 8];
            assign w_b_bytes[gi] = r_b[8*gi +: 8];
        end
    endgenerate

    assign w_a_byte = w_a_bytes[r_idx];
    assign w_b_byte = w_b_bytes[r_idx];

    // Signed compares flip the sign bit of the top byte only, which maps
    // two's complement onto offset binary so the unsigned stage orders it.
    assign w_flip    = r_signed && (r_idx == IDX_MSB);
    assign w_a_stage = {w_a_byte[7] ^ w_flip, w_a_byte[6:0]};
    assign w_b_stage = {w_b_byte[7] ^ w_flip, w_b_byte[6:0]};

    // Cascadable compare stage: equality so far, and greater-than so far.
    assign w_stage_eq = r_eq & (w_a_stage == w_b_stage);
    assign w_stage_gt = r_gt | (r_eq & (w_a_stage > w_b_stage));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: exit RUN on the last byte or as soon as a byte differs.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if ((r_idx == '0) || !w_stage_eq) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, cascade registers and byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_eq     <= 1'b1;
            r_gt     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_signed <= signed_md;
                        r_idx    <= IDX_MSB;
                        r_eq     <= 1'b1;
                        r_gt     <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_eq <= w_stage_eq;
                    r_gt <= w_stage_gt;
                    // The index stops at zero; RUN leaves on that byte anyway.
                    if (r_idx != '0) begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers load from the stage on the edge entering DONE, so the
    // result is valid alongside done and holds until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eq_out <= 1'b0;
            r_gt_out <= 1'b0;
            r_lt_out <= 1'b0;
        end else if ((r_state == S_RUN) && (w_state_next == S_DONE)) begin
            r_eq_out <= w_stage_eq;
            r_gt_out <= w_stage_gt;
            r_lt_out <= ~w_stage_eq & ~w_stage_gt;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign eq_out = r_eq_out;
    assign gt_out = r_gt_out;
    assign lt_out = r_lt_out;

endmodule

// File: tb/tb_seq_byte_compare_ctrl.sv
// Scoreboard bench for seq_byte_compare_ctrl (NBYTES=4).
// The driver pushes the expected result and decision length for each accepted
// request. The monitor pops and checks on every done pulse.
module tb_seq_byte_compare_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          signed_md = 1'b0;
    logic [31:0]   a_in = '0;
    logic [31:0]   b_in = '0;
    logic          busy, done, eq_out, gt_out, lt_out;

    typedef struct {
        logic       eq;
        logic       gt;
        logic       lt;
        int         cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic       s;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   busy_cnt = 0;

    seq_byte_compare_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_md (signed_md),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .eq_out    (eq_out),
        .gt_out    (gt_out),
        .lt_out    (lt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    // Reference: plain integer compare, plus the position of the first
    // differing byte counted from the MSB (all bytes when equal).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic gt;
        int   k;
        gt = s ? ($signed(a) > $signed(b)) : (a > b);
        k = NB;
        for (int i = NB - 1; i >= 0; i--) begin
            if (a[8*i +: 8] != b[8*i +: 8]) begin
                k = NB - i;
                break;
            end
        end
        e.eq = (a == b);
        e.gt = gt;
        e.lt = !(a == b) && !gt;
        e.cyc = k;
        e.a = a;
        e.b = b;
        e.s = s;
        return e;
    endfunction

    // Issue a request at the next edge. Then drive random operand noise, with
    // start held high when hammer is set, through the RUN and DONE edges. The
    // following edge is the earliest one at which a new start is accepted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit hammer);
        exp_t e;
        e = model(a, b, s);
        exp_q.push_back(e);
        start = 1'b1;
        a_in = a;
        b_in = b;
        signed_md = s;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i <= e.cyc; i++) begin
            start = hammer;
            a_in = $urandom;
            b_in = $urandom;
            signed_md = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Monitor: check each done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            else busy_cnt = 0;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn a=%08h b=%08h s=%0d -> eq=%0d gt=%0d lt=%0d busy_cycles=%0d",
                             e.a, e.b, e.s, eq_out, gt_out, lt_out, busy_cnt);
                    chk("eq_out", int'(eq_out), int'(e.eq));
                    chk("gt_out", int'(gt_out), int'(e.gt));
                    chk("lt_out", int'(lt_out), int'(e.lt));
                    chk("busy_cycles", busy_cnt, e.cyc + 1);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_eq", int'(eq_out), 0);
        chk("reset_gt", int'(gt_out), 0);
        chk("reset_lt", int'(lt_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
        issue(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        issue(32'h12345679, 32'h12345678, 1'b0, 1'b0);
        issue(32'h12345678, 32'h12345679, 1'b0, 1'b1);
        issue(32'hFFFFFF00, 32'h00000001, 1'b1, 1'b1);
        issue(32'h7F000000, 32'h7F000000, 1'b1, 1'b1);
        drain();

        // Asynchronous reset during RUN: everything clears at once and no done follows
        start = 1'b1;
        a_in = 32'hCAFE0001;
        b_in = 32'hCAFE0002;
        signed_md = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_eq", int'(eq_out), 0);
        chk("abort_gt", int'(gt_out), 0);
        chk("abort_lt", int'(lt_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("abort_no_done_idle", int'(busy), 0);
        issue(32'h00000005, 32'hFFFFFFFB, 1'b1, 1'b0);
        drain();

        // Random traffic: each byte of B copies A's byte half the time, so
        // every early-exit position and full-length compares all occur.
        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            rb = $urandom;
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 1) == 1) rb[8*i +: 8] = ra[8*i +: 8];
            end
            if ($urandom_range(0, 3) == 0) rb = ra;
            issue(ra, rb, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
